const_bank: RTL and testbench

Parametrised, runtime-programmable constant source for the image-sharpening datapath, replacing fixed hard-wired constant drivers. Holds NUM_CH constant registers of WIDTH bits in a writable shadow bank and an active bank. The active bank drives the sharpening unit; the DLX core writes new values into the shadow bank and commits them atomically, deferred while the datapath asserts hold mid-frame.

---
 rtl/const_bank.sv | 188 ++++++++++++++++++
 tb/tb_const_bank.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/const_bank.sv
// ---------------------------------------------------------------------------
// const_bank
//
// Runtime-programmable constant source for the image-sharpening datapath.
// The block keeps two banks of NUM_CH constants, each WIDTH bits wide:
//   * The DLX core writes new values into the shadow bank.
//   * The active bank drives the sharpening unit.
// A commit copies the whole shadow bank into the active bank on a single
// clock edge. While the datapath asserts hold (mid-frame), the copy waits.
//
// Optional feature (compile-time macro CONST_BANK_LOCK_EN):
//   Adds a 'lock' input. A high level on 'lock' at any clock edge sets a
//   sticky lock bit, and only rst_n clears it. While the bit is set:
//     * every write is rejected, and wr_err pulses;
//     * new commits are ignored;
//     * a commit that is already pending still completes.
//   When the macro is undefined, the port does not exist and the block is
//   never locked.
//
// Ports:
//   clk          in   rising-edge clock for all state
//   rst_n        in   asynchronous active-low reset
//   wr_en        in   shadow write strobe
//   wr_addr      in   shadow channel to write
//   wr_data      in   value to write
//   commit       in   request a shadow->active copy (single-cycle pulse)
//   hold         in   datapath busy; the copy is deferred while high
//   rd_addr      in   shadow readback select
//   lock         in   (CONST_BANK_LOCK_EN only) sets the sticky lock bit
//   rd_data      out  combinational shadow[rd_addr]; 0 when out of range
//   out_const    out  active bank, channel i at [i*WIDTH +: WIDTH]
//   dirty        out  shadow written since the last copy
//   pending      out  commit accepted, copy not yet done
//   commit_done  out  one-cycle pulse after a copy
//   wr_err       out  one-cycle pulse after a rejected write
// ---------------------------------------------------------------------------
module const_bank #(
  parameter int                WIDTH       = 32,
  parameter int                NUM_CH      = 4,
  parameter int                ADDR_W      = 2,
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = 32'h000FF000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    commit,
  input  logic                    hold,
  input  logic [ADDR_W-1:0]       rd_addr,
`ifdef CONST_BANK_LOCK_EN
  input  logic                    lock,
`endif
  output logic [WIDTH-1:0]        rd_data,
  output logic [NUM_CH*WIDTH-1:0] out_const,
  output logic                    dirty,
  output logic                    pending,
  output logic                    commit_done,
  output logic                    wr_err
);

  // IDLE: no commit outstanding.
  // WAIT: a commit was accepted while hold was high.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shadow_q [NUM_CH];
  logic [WIDTH-1:0] active_q [NUM_CH];
  logic             dirty_q;
  logic             done_q;
  logic             err_q;

  logic             locked;
  logic             wr_in_range;
  logic             wr_ok;
  logic             commit_ok;
  logic             do_copy;

`ifdef CONST_BANK_LOCK_EN
  logic lock_q;

  // The lock bit is sticky: only a reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (lock) begin
      lock_q <= 1'b1;
    end
  end

  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  // Range check by matching against each real channel, rather than by
  // comparing with NUM_CH. This stays width-clean when 2^ADDR_W > NUM_CH.
  always_comb begin
    wr_in_range = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_addr == ADDR_W'(i)) begin
        wr_in_range = 1'b1;
      end
    end
  end

  assign wr_ok     = wr_en && wr_in_range && !locked;
  assign commit_ok = commit && !locked;

  // Copy on any edge with an outstanding (or fresh) commit and no hold.
  // A commit that is already pending completes even if the lock was set
  // after it was accepted.
  assign do_copy   = !hold && ((state_q == WAIT) || commit_ok);

  // Shadow readback. Unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_data = shadow_q[i];
      end
    end
  end

  // Banks, flags and commit FSM.
  // The active bank samples the shadow bank's pre-edge values, so a write
  // on the copy edge lands only in the shadow bank and keeps dirty set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= DEFAULT_VAL;
        active_q[i] <= DEFAULT_VAL;
      end
      state_q <= IDLE;
      dirty_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (do_copy) begin
        for (int i = 0; i < NUM_CH; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end

      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ok && (wr_addr == ADDR_W'(i))) begin
          shadow_q[i] <= wr_data;
        end
      end

      if (wr_ok) begin
        dirty_q <= 1'b1;
      end else if (do_copy) begin
        dirty_q <= 1'b0;
      end

      done_q <= do_copy;
      err_q  <= wr_en && !wr_ok;

      case (state_q)
        IDLE: begin
          if (commit_ok && hold) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!hold) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_const[g*WIDTH +: WIDTH] = active_q[g];
  end

  assign dirty       = dirty_q;
  assign pending     = (state_q == WAIT);
  assign commit_done = done_q;
  assign wr_err      = err_q;

endmodule

// File: tb/tb_const_bank.sv
// ---------------------------------------------------------------------------
// tb_const_bank
//
// Bench for const_bank, configured with three channels behind a two-bit
// address so that address 3 exercises the unmapped-channel path.
//
// A transaction-level model advances once per clock:
//   * commit requests latch;
//   * with hold low, the whole shadow bank is copied;
//   * then the write applies.
// A single compare process checks every DUT output against this model on
// each falling edge. Hand-computed literal checks pin the model to known
// values.
// ---------------------------------------------------------------------------
module tb_const_bank;

  localparam int          W   = 32;
  localparam int          NCH = 3;
  localparam int          AW  = 2;
  localparam logic [31:0] DEF = 32'h000FF000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [W-1:0]    wr_data = '0;
  logic            commit = 1'b0;
  logic            hold = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic            lock = 1'b0;
  logic [W-1:0]    rd_data;
  logic [NCH*W-1:0] out_const;
  logic            dirty;
  logic            pending;
  logic            commit_done;
  logic            wr_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state.
  logic [31:0] m_shadow [NCH];
  logic [31:0] m_active [NCH];
  logic        m_dirty, m_pending, m_done, m_err, m_lock;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        cm;
    logic        hd;
  } vec_t;

  vec_t vecs [7];

  const_bank #(
    .WIDTH(W),
    .NUM_CH(NCH),
    .ADDR_W(AW),
    .DEFAULT_VAL(DEF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit(commit),
    .hold(hold),
    .rd_addr(rd_addr),
`ifdef CONST_BANK_LOCK_EN
    .lock(lock),
`endif
    .rd_data(rd_data),
    .out_const(out_const),
    .dirty(dirty),
    .pending(pending),
    .commit_done(commit_done),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus.
  // wr_en and commit return low afterwards. hold keeps its level.
  task automatic applyStimulus(input logic we, input logic [1:0] a,
                               input logic [31:0] d, input logic cm,
                               input logic hd);
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    commit  = cm;
    hold    = hd;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic model_step();
    logic locked_now, wr_ok, take, copy_now;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = DEF;
        m_active[i] = DEF;
      end
      m_dirty = 0; m_pending = 0; m_done = 0; m_err = 0; m_lock = 0;
    end else begin
      locked_now = m_lock;
      wr_ok      = wr_en && (int'(wr_addr) < NCH) && !locked_now;
      take       = commit && !locked_now;
      copy_now   = !hold && (m_pending || take);
      if (copy_now) m_active = m_shadow;
      m_done    = copy_now;
      m_err     = wr_en && !wr_ok;
      m_pending = copy_now ? 1'b0 : (m_pending || take);
      m_dirty   = wr_ok ? 1'b1 : (copy_now ? 1'b0 : m_dirty);
      if (wr_ok) m_shadow[wr_addr] = wr_data;
`ifdef CONST_BANK_LOCK_EN
      if (lock) m_lock = 1'b1;
`endif
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Compare process: every output against the model, each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int i = 0; i < NCH; i++) begin
          checkOutput($sformatf("model out_const[%0d]", i), out_const[i*W +: W], m_active[i]);
        end
        checkOutput("model rd_data", rd_data,
                    (int'(rd_addr) < NCH) ? m_shadow[rd_addr] : 32'h0);
        checkOutput("model dirty", {31'b0, dirty}, {31'b0, m_dirty});
        checkOutput("model pending", {31'b0, pending}, {31'b0, m_pending});
        checkOutput("model commit_done", {31'b0, commit_done}, {31'b0, m_done});
        checkOutput("model wr_err", {31'b0, wr_err}, {31'b0, m_err});
      end
    end
  end

  initial begin
    vecs[0] = '{1'b1, 2'd0, 32'h11, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 32'h22, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 2'd2, 32'h33, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 32'h00, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 2'd3, 32'h44, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values.
    for (int i = 0; i < NCH; i++) begin
      checkOutput("reset out_const", out_const[i*W +: W], 32'h000FF000);
    end
    for (int a = 0; a < NCH; a++) begin
      rd_addr = AW'(a);
      #1 checkOutput("reset rd_data", rd_data, 32'h000FF000);
    end
    checkOutput("reset flags", {28'b0, dirty, pending, commit_done, wr_err}, 32'h0);

    // Write ch2, then commit with hold low.
    applyStimulus(1'b1, 2'd2, 32'h00000009, 1'b0, 1'b0);
    rd_addr = 2'd2;
    #1 checkOutput("write rd_data ch2", rd_data, 32'h00000009);
    checkOutput("write dirty", {31'b0, dirty}, 32'h1);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("commit ch2", out_const[2*W +: W], 32'h00000009);
    checkOutput("commit ch0", out_const[0 +: W], 32'h000FF000);
    checkOutput("commit ch1", out_const[W +: W], 32'h000FF000);
    checkOutput("commit_done pulse", {31'b0, commit_done}, 32'h1);
    checkOutput("commit dirty", {31'b0, dirty}, 32'h0);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("commit_done drop", {31'b0, commit_done}, 32'h0);

    // Deferred commit under hold.
    applyStimulus(1'b1, 2'd0, 32'h0000FFFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    checkOutput("deferred ch0 held", out_const[0 +: W], 32'h000FF000);
    checkOutput("deferred pending", {31'b0, pending}, 32'h1);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("deferred ch0 copied", out_const[0 +: W], 32'h0000FFFF);
    checkOutput("deferred pending clr", {31'b0, pending}, 32'h0);
    checkOutput("deferred commit_done", {31'b0, commit_done}, 32'h1);

    // Write and commit in the same cycle.
    applyStimulus(1'b1, 2'd1, 32'h0000000A, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h0000000B, 1'b1, 1'b0);
    rd_addr = 2'd1;
    #1 checkOutput("collision active ch1", out_const[W +: W], 32'h0000000A);
    checkOutput("collision shadow ch1", rd_data, 32'h0000000B);
    checkOutput("collision dirty", {31'b0, dirty}, 32'h1);

    // Unmapped address.
    applyStimulus(1'b1, 2'd3, 32'h00000055, 1'b0, 1'b0);
    checkOutput("bad addr wr_err", {31'b0, wr_err}, 32'h1);
    rd_addr = 2'd3;
    #1 checkOutput("bad addr rd_data", rd_data, 32'h0);
    rd_addr = 2'd1;
    #1 checkOutput("bad addr ch1 intact", rd_data, 32'h0000000B);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("bad addr wr_err drop", {31'b0, wr_err}, 32'h0);

    // Mixed vectors, checked by the model only.
    for (int v = 0; v < 7; v++) begin
      rd_addr = AW'(v % 4);
      applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].cm, vecs[v].hd);
    end

    // Reset while a commit is waiting.
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    checkOutput("wait pending", {31'b0, pending}, 32'h1);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset mid-wait pending", {31'b0, pending}, 32'h0);
    for (int i = 0; i < NCH; i++) begin
      checkOutput("reset mid-wait out", out_const[i*W +: W], 32'h000FF000);
    end
    checkOutput("reset mid-wait dirty", {31'b0, dirty}, 32'h0);
    hold = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("after reset ch0", out_const[0 +: W], 32'h000FF000);

`ifdef CONST_BANK_LOCK_EN
    // Locked: the write is rejected and the commit is ignored.
    lock = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    lock = 1'b0;
    applyStimulus(1'b1, 2'd0, 32'h00000001, 1'b1, 1'b0);
    rd_addr = 2'd0;
    #1 checkOutput("lock wr_err", {31'b0, wr_err}, 32'h1);
    checkOutput("lock shadow ch0", rd_data, 32'h000FF000);
    checkOutput("lock no commit", {31'b0, commit_done}, 32'h0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 2'd0, 32'h00000001, 1'b0, 1'b0);
    #1 checkOutput("unlock wr_err", {31'b0, wr_err}, 32'h0);
    checkOutput("unlock shadow ch0", rd_data, 32'h00000001);
`endif

    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
